// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_seq
//   Clocked, handshaked ALU. A request (a, b, op) is taken when
//   in_valid && in_ready; the registered result (f plus carry/zero/err
//   flags) is presented with out_valid and held until the consumer asserts
//   out_ready. Single-cycle ops are ready one cycle after acceptance. With
//   the optional multiplier, op 000 runs a WIDTH_B-step shift-add multiply
//   and is ready WIDTH_B+1 cycles after acceptance.
//
// Configuration macro:
//   ALU_SEQ_MUL_EN  - builds the multi-cycle shift-add multiplier for op 000.
//                     When undefined, op 000 completes in one cycle with
//                     f=0, carry=0, zero=1, err=1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request this cycle (combinational)
//   a          operand a, unsigned, WIDTH_A bits
//   b          operand b, unsigned, WIDTH_B bits
//   op         opcode: 000 MUL, 001 ADD, 010 SUB, 011 AND, 100 OR,
//              101 LT, 110 INCA, 111 INCB
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   f          registered result, WIDTH_F bits
//   carry      carry / borrow / multiply-overflow flag
//   zero       f == 0
//   err        illegal opcode
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 5,
    parameter int WIDTH_F = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_F-1:0] f,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    // Operands are zero-extended one bit past the result so that bit WIDTH_F
    // carries the carry/borrow out of the single-cycle arithmetic ops.
    localparam int EXT_W = WIDTH_F + 1;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_LT   = 3'b101;
    localparam logic [2:0] OP_INCA = 3'b110;
    localparam logic [2:0] OP_INCB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH_F-1:0]   f_q, f_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;

    logic [EXT_W-1:0]     a_ext, b_ext, alu_res;
    logic                 alu_carry_en, alu_err;
    logic [WIDTH_F-1:0]   alu_f;
    logic                 alu_carry;
    logic                 accept;

`ifdef ALU_SEQ_MUL_EN
    localparam int ACC_W = WIDTH_A + WIDTH_B;
    localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH_B-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_step;
    logic               mul_last;
`endif

    // A new request can be taken when idle, or when the current result is
    // being consumed this very cycle (back-to-back operation).
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Single-cycle result for every opcode except MUL. Opcode 000 lands in
    // the default branch and reports err, which the multiplier build
    // overrides on completion.
    always_comb begin
        a_ext        = EXT_W'(a);
        b_ext        = EXT_W'(b);
        alu_res      = '0;
        alu_carry_en = 1'b0;
        alu_err      = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res      = a_ext + b_ext;
                alu_carry_en = 1'b1;
            end
            OP_SUB: begin
                alu_res      = a_ext - b_ext;
                alu_carry_en = 1'b1;
            end
            OP_AND:  alu_res = a_ext & b_ext;
            OP_OR:   alu_res = a_ext | b_ext;
            OP_LT:   alu_res = EXT_W'(a_ext < b_ext);
            OP_INCA: begin
                alu_res      = a_ext + EXT_W'(1);
                alu_carry_en = 1'b1;
            end
            OP_INCB: begin
                alu_res      = b_ext + EXT_W'(1);
                alu_carry_en = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
        alu_f     = alu_res[WIDTH_F-1:0];
        alu_carry = alu_carry_en & alu_res[WIDTH_F];
    end

`ifdef ALU_SEQ_MUL_EN
    // One shift-add step; the final step's sum is also the product used to
    // form f and the overflow flag.
    always_comb begin
        acc_step = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
        mul_last = (cnt_q == CNT_W'(WIDTH_B - 1));
    end
`endif

    // Next-state and next-output logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    f_d         = alu_f;
                    carry_d     = alu_carry;
                    zero_d      = (alu_f == '0);
                    err_d       = alu_err;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_d     = BUSY;
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        a_sh_d      = ACC_W'(a);
                        b_sh_d      = b;
                        cnt_d       = '0;
                    end
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (mul_last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    f_d         = WIDTH_F'(acc_step);
                    carry_d     = |(acc_step >> WIDTH_F);
                    zero_d      = (WIDTH_F'(acc_step) == '0);
                    err_d       = 1'b0;
                    cnt_d       = '0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        f         = f_q;
        carry     = carry_q;
        zero      = zero_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq with default widths. Follows the
//   ALU_SEQ_MUL_EN macro so the same file covers both builds.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int WA = 4;
    localparam int WB = 5;
    localparam int WF = 5;
    localparam int MAX_WAIT = 50;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [WF-1:0] f;
    logic          carry;
    logic          zero;
    logic          err;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [2:0] op;
        int         a;
        int         b;
        int         expF;
        int         expC;
        int         expZ;
        int         expE;
        int         expLat;
    } vec_t;

    vec_t vecs[11];

    alu_seq #(
        .WIDTH_A(WA),
        .WIDTH_B(WB),
        .WIDTH_F(WF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so a wedged run still terminates with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode rules.
    task automatic model(input logic [2:0] mop, input int ma, input int mb,
                         output int ef, output int ec, output int ez,
                         output int ee, output int elat);
        int modF;
        int s;
        modF = 1 << WF;
        ec   = 0;
        ee   = 0;
        elat = 1;
        case (mop)
            3'd0: begin
`ifdef ALU_SEQ_MUL_EN
                s    = ma * mb;
                ef   = s % modF;
                ec   = (s >= modF) ? 1 : 0;
                elat = WB + 1;
`else
                ef   = 0;
                ee   = 1;
`endif
            end
            3'd1: begin s = ma + mb; ef = s % modF; ec = (s >= modF) ? 1 : 0; end
            3'd2: begin ef = (ma - mb + 2 * modF) % modF; ec = (ma < mb) ? 1 : 0; end
            3'd3: ef = ma & mb;
            3'd4: ef = ma | mb;
            3'd5: ef = (ma < mb) ? 1 : 0;
            3'd6: begin s = ma + 1; ef = s % modF; ec = (s >= modF) ? 1 : 0; end
            default: begin s = mb + 1; ef = s % modF; ec = (s >= modF) ? 1 : 0; end
        endcase
        ez = (ef == 0) ? 1 : 0;
    endtask

    // Presents a request from just after a rising edge, waits for it to be
    // taken, scrambles the inputs, then counts cycles until out_valid.
    task automatic applyStimulus(input logic [2:0] sop, input int sa, input int sb,
                                 output int lat);
        int waited;
        op       = sop;
        a        = WA'(sa);
        b        = WB'(sb);
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkVal("accept_timeout", 0, 1);
            in_valid = 1'b0;
            lat      = -1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WA'($urandom);
        b        = WB'($urandom);
        op       = 3'($urandom);
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < MAX_WAIT);
    endtask

    // Compares the presented result, optionally stalls the consumer to make
    // sure the result holds, then consumes it.
    task automatic checkOutput(input string name, input int ef, input int ec,
                               input int ez, input int ee, input int elat,
                               input int lat, input int stall);
        checkVal({name, "_lat"},   lat, elat);
        checkVal({name, "_f"},     int'(f), ef);
        checkVal({name, "_carry"}, int'(carry), ec);
        checkVal({name, "_zero"},  int'(zero), ez);
        checkVal({name, "_err"},   int'(err), ee);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkVal({name, "_hold_f"},     int'(f), ef);
            checkVal({name, "_hold_valid"}, int'(out_valid), 1);
            checkVal({name, "_hold_rdy"},   int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int ef, ec, ez, ee, elat;
        logic [2:0] rop;
        int ra, rb;

        // Directed vectors; MUL rows depend on the build.
        vecs[0]  = '{3'd1, 15, 31, 5'h0E, 1, 0, 0, 1};
        vecs[1]  = '{3'd2,  3,  5, 5'h1E, 1, 0, 0, 1};
        vecs[2]  = '{3'd5,  2,  9, 1,     0, 0, 0, 1};
        vecs[3]  = '{3'd5,  9,  3, 0,     0, 1, 0, 1};
        vecs[4]  = '{3'd3, 15, 26, 5'h0A, 0, 0, 0, 1};
        vecs[5]  = '{3'd4,  5, 18, 5'h17, 0, 0, 0, 1};
        vecs[6]  = '{3'd6, 15,  0, 5'h10, 0, 0, 0, 1};
        vecs[7]  = '{3'd7,  0, 31, 0,     1, 1, 0, 1};
        vecs[8]  = '{3'd2,  5,  5, 0,     0, 1, 0, 1};
`ifdef ALU_SEQ_MUL_EN
        vecs[9]  = '{3'd0,  7,  6, 5'h0A, 1, 0, 0, WB + 1};
        vecs[10] = '{3'd0,  3,  5, 15,    0, 0, 0, WB + 1};
`else
        vecs[9]  = '{3'd0,  7,  6, 0,     0, 1, 1, 1};
        vecs[10] = '{3'd0,  3,  5, 0,     0, 1, 1, 1};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;

        #2;
        checkVal("rst_out_valid", int'(out_valid), 0);
        checkVal("rst_in_ready",  int'(in_ready), 1);
        checkVal("rst_f",         int'(f), 0);
        checkVal("rst_carry",     int'(carry), 0);
        checkVal("rst_zero",      int'(zero), 0);
        checkVal("rst_err",       int'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].expF, vecs[i].expC,
                        vecs[i].expZ, vecs[i].expE, vecs[i].expLat, lat, 0);
        end

        $display("[TB] back-pressure and back-to-back accept");
        op       = 3'd1;
        a        = WA'(1);
        b        = WB'(1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd2;
        a  = WA'(7);
        b  = WB'(2);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkVal("bp_valid", int'(out_valid), 1);
            checkVal("bp_f",     int'(f), 2);
            checkVal("bp_ready", int'(in_ready), 0);
            @(posedge clk);
        end
        @(negedge clk);
        checkVal("bp_f_before_release", int'(f), 2);
        out_ready = 1'b1;
        #1;
        checkVal("bp_ready_same_cycle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkVal("b2b_valid", int'(out_valid), 1);
        checkVal("b2b_f",     int'(f), 5);
        checkVal("b2b_carry", int'(carry), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkVal("after_drain_valid", int'(out_valid), 0);

        $display("[TB] asynchronous reset during an operation");
        @(posedge clk);
        #1;
`ifdef ALU_SEQ_MUL_EN
        op       = 3'd0;
        a        = WA'(7);
        b        = WB'(6);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkVal("mid_mul_ready", int'(in_ready), 0);
        checkVal("mid_mul_valid", int'(out_valid), 0);
`else
        op       = 3'd1;
        a        = WA'(1);
        b        = WB'(1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkVal("pre_rst_valid", int'(out_valid), 1);
        checkVal("pre_rst_f",     int'(f), 2);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_valid", int'(out_valid), 0);
        checkVal("async_rst_f",     int'(f), 0);
        checkVal("async_rst_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        checkVal("held_rst_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        applyStimulus(3'd1, 2, 3, lat);
        checkOutput("post_rst_add", 5, 0, 0, 0, 1, lat, 0);

        $display("[TB] randomized transactions against the reference model");
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = int'($urandom_range(0, (1 << WA) - 1));
            rb  = int'($urandom_range(0, (1 << WB) - 1));
            model(rop, ra, rb, ef, ec, ez, ee, elat);
            applyStimulus(rop, ra, rb, lat);
            checkOutput($sformatf("rnd%0d_op%0d", i, rop), ef, ec, ez, ee, elat,
                        lat, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
